// File: rtl/local_flit_receiver.sv
// Reassembles MSB-first flits from the router's local port into spike packets,
// filters them on destination and queues them for the neuron's axon input.
module local_flit_receiver #(
  parameter int         FLIT_SIZE          = 4,
  parameter int         PACKET_SIZE        = 32,
  parameter int         FIFO_DEPTH         = 2,
  parameter int         AXON_CNT_BIT_WIDTH = 2,
  parameter logic [3:0] X_ID               = 4'd0,
  parameter logic [3:0] Y_ID               = 4'd0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [FLIT_SIZE-1:0]          flit_in,
  input  logic                          write_req,
  output logic                          full,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [AXON_CNT_BIT_WIDTH-1:0] axon_id,
  output logic [PACKET_SIZE-1:0]        packet_out,
  output logic                          misroute,
  output logic                          overflow_err
);

  localparam int FLITS   = PACKET_SIZE / FLIT_SIZE;
  localparam int CNT_W   = $clog2(FLITS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int SHIFT_W = PACKET_SIZE - FLIT_SIZE;

  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic [PACKET_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic                   mis_q, mis_d, ovf_q, ovf_d;

  logic                   accept, last, dest_ok, push, pop;
  logic [PACKET_SIZE-1:0] pkt;

  // Handshake: a head packet transfers on any edge where spike_valid and
  // spike_ready are both high; head data holds while spike_ready is low.
  assign full        = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign spike_valid = (count_q != '0);
  assign packet_out  = mem_q[rd_ptr_q];
  assign axon_id     = mem_q[rd_ptr_q][AXON_CNT_BIT_WIDTH-1:0];
  assign misroute    = mis_q;
  assign overflow_err = ovf_q;

  // The final flit is merged combinationally so the packet is pushed on the
  // same edge it completes.
  assign accept  = write_req && !full;
  assign last    = accept && (cnt_q == CNT_W'(FLITS - 1));
  assign pkt     = {shift_q, flit_in};
  assign dest_ok = (pkt[PACKET_SIZE-1 -: 8] == {X_ID, Y_ID});
  assign push    = last && dest_ok;
  assign pop     = spike_valid && spike_ready;

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mis_d    = last && !dest_ok;
    ovf_d    = ovf_q || (write_req && full);
    if (accept) begin
      shift_d = {shift_q[SHIFT_W-FLIT_SIZE-1:0], flit_in};
      cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mis_q    <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mis_q    <= mis_d;
      ovf_q    <= ovf_d;
      if (push) mem_q[wr_ptr_q] <= pkt;
    end
  end

endmodule

// File: tb/tb_local_flit_receiver.sv
// Directed and randomized bench for local_flit_receiver against a packet-queue
// reference model.
module tb_local_flit_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  flit_in;
  logic        write_req;
  logic        full;
  logic        spike_valid;
  logic        spike_ready;
  logic [1:0]  axon_id;
  logic [31:0] packet_out;
  logic        misroute;
  logic        overflow_err;

  local_flit_receiver #(
    .FLIT_SIZE(4), .PACKET_SIZE(32), .FIFO_DEPTH(2),
    .AXON_CNT_BIT_WIDTH(2), .X_ID(4'd0), .Y_ID(4'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .write_req(write_req),
    .full(full), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .axon_id(axon_id), .packet_out(packet_out), .misroute(misroute),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_acc;
  int          m_nflit;
  logic        m_ovf;
  logic        m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":full"},        32'(full),         32'(exp_q.size() == 2));
    chk({tag, ":spike_valid"}, 32'(spike_valid),  32'(exp_q.size() != 0));
    chk({tag, ":misroute"},    32'(misroute),     32'(m_mis));
    chk({tag, ":overflow"},    32'(overflow_err), 32'(m_ovf));
    if (exp_q.size() != 0) begin
      chk({tag, ":packet_out"}, packet_out,     exp_q[0]);
      chk({tag, ":axon_id"},    32'(axon_id),   exp_q[0] % 4);
    end
  endtask

  task automatic do_reset();
    write_req   = 1'b0;
    flit_in     = 4'h0;
    spike_ready = 1'b0;
    rst_n       = 1'b0;
    exp_q.delete();
    m_acc   = 32'h0;
    m_nflit = 0;
    m_ovf   = 1'b0;
    m_mis   = 1'b0;
    #2;
    chk("rst:full",         32'(full),         32'h0);
    chk("rst:spike_valid",  32'(spike_valid),  32'h0);
    chk("rst:axon_id",      32'(axon_id),      32'h0);
    chk("rst:packet_out",   packet_out,        32'h0);
    chk("rst:misroute",     32'(misroute),     32'h0);
    chk("rst:overflow_err", 32'(overflow_err), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: apply inputs, advance the model by the rules, then compare.
  task automatic cycle(input logic wr, input logic [3:0] f, input logic rdy, input string tag);
    logic push_now;
    push_now    = 1'b0;
    write_req   = wr;
    flit_in     = f;
    spike_ready = rdy;
    m_mis       = 1'b0;
    if (wr) begin
      if (exp_q.size() == 2) begin
        m_ovf = 1'b1;
      end else begin
        m_acc = (m_acc << 4) | 32'(f);
        m_nflit++;
        if (m_nflit == 8) begin
          m_nflit = 0;
          if ((m_acc >> 24) == 32'h0) push_now = 1'b1;
          else m_mis = 1'b1;
        end
      end
    end
    if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (push_now) exp_q.push_back(m_acc);
    @(posedge clk);
    #1;
    cyc++;
    write_req = 1'b0;
    check_outputs(tag);
  endtask

  // mode: 0 never ready, 1 always, 2 toggling, 3 random, 4 ready on last flit only
  task automatic send_pkt(input logic [31:0] p, input int mode, input string tag);
    logic rdy;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = cyc[0];
        3:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (i == 7);
      endcase
      cycle(1'b1, 4'((p >> (28 - 4 * i)) & 32'hF), rdy, tag);
    end
  endtask

  initial begin
    logic [31:0] p;
    do_reset();

    // single packet, latency and decode
    send_pkt(32'h0000_1237, 0, "t1");
    chk("t1:packet_out", packet_out, 32'h0000_1237);
    chk("t1:axon_id", 32'(axon_id), 32'h3);
    chk("t1:valid", 32'(spike_valid), 32'h1);

    // fill, then a flit while full
    send_pkt(32'h0000_4562, 0, "t2");
    chk("t2:full", 32'(full), 32'h1);
    cycle(1'b1, 4'hA, 1'b0, "t2_17th");
    chk("t2:overflow", 32'(overflow_err), 32'h1);
    chk("t2:head_kept", packet_out, 32'h0000_1237);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b1, "t2_drain");
    chk("t2:overflow_sticky", 32'(overflow_err), 32'h1);
    chk("t2:empty", 32'(spike_valid), 32'h0);
    do_reset();

    // wrong destination
    send_pkt(32'h1000_0005, 0, "t3");
    chk("t3:misroute", 32'(misroute), 32'h1);
    chk("t3:no_push", 32'(spike_valid), 32'h0);
    cycle(1'b0, 4'h0, 1'b0, "t3_idle");
    chk("t3:misroute_pulse", 32'(misroute), 32'h0);

    // push and pop on the same edge
    send_pkt(32'h0000_00A1, 0, "t4a");
    send_pkt(32'h0000_00B2, 4, "t4b");
    chk("t4:head_new", packet_out, 32'h0000_00B2);
    chk("t4:not_full", 32'(full), 32'h0);
    cycle(1'b0, 4'h0, 1'b1, "t4_drain");

    // reset mid-packet
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 9), 1'b0, "t5_partial");
    do_reset();
    send_pkt(32'h0000_3456, 0, "t5");
    chk("t5:packet_out", packet_out, 32'h0000_3456);
    chk("t5:axon_id", 32'(axon_id), 32'h2);
    cycle(1'b0, 4'h0, 1'b1, "t5_drain");

    // streamed packets with toggling ready
    send_pkt(32'h0000_0011, 2, "t6");
    send_pkt(32'h0000_0022, 2, "t6");
    send_pkt(32'h0000_0033, 2, "t6");
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, cyc[0], "t6_drain");
    chk("t6:drained", 32'(spike_valid), 32'h0);
    chk("t6:no_overflow", 32'(overflow_err), 32'h0);

    // randomized traffic with gaps, misroutes and back-pressure
    for (int k = 0; k < 40; k++) begin
      p = $urandom();
      if ($urandom_range(0, 3) != 0) p[31:24] = 8'h00;
      else p[31:24] = 8'($urandom_range(1, 255));
      for (int i = 0; i < 8; i++) begin
        while ($urandom_range(0, 3) == 0)
          cycle(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rnd_gap");
        cycle(1'b1, 4'((p >> (28 - 4 * i)) & 32'hF), 1'($urandom_range(0, 1)), "rnd");
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 1'b1, "rnd_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/local_flit_receiver.md
# local_flit_receiver

Downstream stage of the router's local output port inside a neuron cell. It takes 4-bit flits from the router's local port, reassembles them into 32-bit spike packets, checks the destination against the cell's coordinates, and buffers accepted packets in a small FIFO. Packets are presented to the neuron's axon input as decoded axon spike events through a valid/ready handshake. Its `full` output is the router's `local_neuron_full` back-pressure.

## Interface
- `FLIT_SIZE`, 4, flit width in bits.
- `PACKET_SIZE`, 32, packet width; must be a multiple of `FLIT_SIZE` (8 flits per packet at defaults).
- `FIFO_DEPTH`, 2, number of assembled packets buffered; must be a power of 2, ≥2.
- `AXON_CNT_BIT_WIDTH`, 2, width of the decoded axon index.
- `X_ID`, 0, cell X coordinate, 4 bits.
- `Y_ID`, 0, cell Y coordinate, 4 bits.
- `clk`  in  1  single clock, rising edge; it is the neuron clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flit_in`  in  FLIT_SIZE  flit from router `local_out`.
- `write_req`  in  1  router `write_req_local`; flit on `flit_in` is valid this cycle.
- `full`  out  1  to router `local_neuron_full`; FIFO holds `FIFO_DEPTH` packets.
- `spike_valid`  out  1  head packet available.
- `spike_ready`  in  1  neuron consumes the head packet.
- `axon_id`  out  AXON_CNT_BIT_WIDTH  head packet bits [AXON_CNT_BIT_WIDTH-1:0].
- `packet_out`  out  PACKET_SIZE  full head packet.
- `misroute`  out  1  one-cycle pulse when a completed packet is dropped for a wrong destination.
- `overflow_err`  out  1  sticky flag: a flit arrived while `full` was high.

## Operation
- Packet format:
  - [31:28] destination X, [27:24] destination Y.
  - [23:20] source X, [19:16] source Y.
  - [15:0] payload; axon index in the low bits.
- Flits arrive MSB first: the first flit is bits [31:28] and the 8th flit is bits [3:0].
- Assembler:
  - Shift register plus a flit counter of width log2(PACKET_SIZE/FLIT_SIZE).
  - A flit is accepted when `write_req && !full`: it shifts in and the counter increments.
  - The counter wraps from 7 to 0 on the final flit.
- On the final flit, the packet is formed from the shifted-in value and the final flit together:
  - Destination equals {X_ID, Y_ID}: push into the FIFO.
  - Otherwise: do not push, and pulse `misroute` high for exactly the next cycle.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count (0..FIFO_DEPTH).
  - Pop occurs when `spike_valid && spike_ready`.
  - `spike_valid` = (count != 0). `packet_out` and `axon_id` are driven from the head entry.
- `full` = (count == FIFO_DEPTH), a function of registered count only. Because a push happens only on a final flit, `full` can rise only at a packet boundary.
- Flit while `full`=1:
  - Discarded; shift register and counter unchanged.
  - `overflow_err` is set and stays set until reset. The router is required never to do this.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pop with `spike_ready` while count==0: no effect.
- Reset (asserted at any time, including mid-packet):
  - Partial packet discarded; counter, pointers and count cleared.
  - Reset values: `full`=0, `spike_valid`=0, `axon_id`=0, `packet_out`=0, `misroute`=0, `overflow_err`=0.

## Timing
- Flit sampled on the rising edge where `write_req`=1 and `full`=0.
- Latency: 8th flit sampled at edge N → `spike_valid`=1 after edge N (visible in cycle N+1) if the FIFO was empty → earliest pop at edge N+1.
- `misroute` is high during the cycle after edge N only.
- `full` rises in the cycle after the push that makes count==FIFO_DEPTH. It falls in the cycle after a pop that is not matched by a push.
- Back-to-back packets with no gap are accepted at 1 flit per cycle while not full.
- Head data is stable while `spike_valid`=1 and `spike_ready`=0.

## Test plan
- Reset then 8 flits 0,0,0,0,1,2,3,7 (X_ID=Y_ID=0) with `spike_ready`=0 → `spike_valid`=1 one cycle after flit 8; `packet_out`=32'h00001237, `axon_id`=3.
- Two packets with `spike_ready`=0, then a 17th flit → `full`=1 after packet 2; 17th flit ignored; `overflow_err`=1 and stays 1.
- Packet with destination X=1 → no push, `spike_valid` stays 0, `misroute` high for exactly 1 cycle.
- FIFO holds 1 packet; `spike_ready`=1 on the same edge the next packet's 8th flit arrives → count stays 1, head becomes the new packet next cycle, `full` never asserts.
- `rst_n` pulsed low after 5 flits, then one full 8-flit packet → only the post-reset packet appears with correct value; no residue of the partial packet.
- 3 packets streamed with `spike_ready` toggling 1/0 each cycle → all 3 delivered in order, `full` never high, `overflow_err`=0.
